// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control unit.
// Covers FSM states, opcode values, ALU selector encodings and per-state output decode.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'd0,
    ALU_OP_SUB   = 2'd1,
    ALU_OP_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } alu_src_b_t;

  typedef enum logic [1:0] {
    CLS_LOAD   = 2'd0,
    CLS_STORE  = 2'd1,
    CLS_RTYPE  = 2'd2,
    CLS_BRANCH = 2'd3
  } instr_cls_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write_cond;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    logic       mem_to_reg;
    logic       pc_source;
    alu_op_t    alu_op;
    logic       illegal;
  } ctrl_t;

  // pc_write is absent: in FETCH it also depends on the memory handshake.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
      end
      S_DECODE: begin
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_OP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_cu_opcode_decoder.sv
// Combinational opcode classifier: maps the 7-bit opcode onto an instruction class.
module opcode_decoder
  import cu_pkg::*;
(
  input  logic [6:0] opcode_i,
  output instr_cls_t cls_o,
  output logic       valid_o
);

  always_comb begin
    cls_o   = CLS_RTYPE;
    valid_o = 1'b1;
    case (opcode_i)
      OP_LOAD:   cls_o = CLS_LOAD;
      OP_STORE:  cls_o = CLS_STORE;
      OP_RTYPE:  cls_o = CLS_RTYPE;
      OP_BRANCH: cls_o = CLS_BRANCH;
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Moore control FSM for a multicycle load/store/R-type/BEQ datapath,
// with a retired-instruction counter and a sticky illegal-opcode trap.
//
// state    | meaning
// FETCH    | read instruction, PC += 4 when memory completes
// DECODE   | classify opcode, precompute branch target
// MEM_ADDR | rs1 + imm effective address
// MEM_RD   | load data read, waits on memory
// MEM_WB   | load result to register file
// MEM_WR   | store write, waits on memory
// EXEC_R   | R-type ALU operation
// R_WB     | R-type result to register file
// BRANCH   | BEQ compare, PC <- target when zero
// TRAP     | unsupported opcode, parked until reset
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter bit          FETCH_WAIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_to_reg,
  output logic             pc_source,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q;
  logic             is_load_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             mem_done;
  instr_cls_t       dec_cls;
  logic             dec_valid;

  // The branch decision is made by the datapath as pc_write_cond & zero.
  logic unused_zero;
  assign unused_zero = zero;

  opcode_decoder u_dec (
    .opcode_i (opcode),
    .cls_o    (dec_cls),
    .valid_o  (dec_valid)
  );

  assign mem_done = FETCH_WAIT ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!dec_valid) begin
          state_d = S_TRAP;
        end else begin
          case (dec_cls)
            CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
            CLS_RTYPE:           state_d = S_EXEC_R;
            CLS_BRANCH:          state_d = S_BRANCH;
            default:             state_d = S_TRAP;
          endcase
        end
      end
      S_MEM_ADDR: begin
        state_d = is_load_q ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_done) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_done) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: begin
        state_d = S_R_WB;
      end
      S_R_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctrl_q    <= state_ctrl(S_FETCH);
      is_load_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
      if (state_q == S_DECODE) is_load_q <= (dec_cls == CLS_LOAD);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Write enables are masked by reset so an abandoned instruction writes nothing.
  assign pc_write      = rst_n & (state_q == S_FETCH) & mem_done;
  assign pc_write_cond = rst_n & ctrl_q.pc_write_cond;
  assign ir_write      = rst_n & ctrl_q.ir_write;
  assign mem_write     = rst_n & ctrl_q.mem_write;
  assign reg_write     = rst_n & ctrl_q.reg_write;
  assign mem_read      = ctrl_q.mem_read;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign pc_source     = ctrl_q.pc_source;
  assign alu_op        = ctrl_q.alu_op;
  assign illegal       = ctrl_q.illegal;
  assign retired       = retired_q;

  a_rw_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(mem_read && mem_write));

  a_trap_quiet : assert property (
    @(posedge clk) disable iff (!rst_n)
    illegal |-> !(pc_write || pc_write_cond || ir_write || mem_read ||
                  mem_write || reg_write));

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: instruction-level expectation queue checked every cycle.
module tb_multicycle_cu;
  import cu_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, zero, mem_ready;
  logic [6:0] opcode;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
  logic       alu_src_a, mem_to_reg, pc_source, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] retired;

  logic       rst_nw;
  logic [6:0] opcode_nw;
  logic       nw_pc_write, nw_pc_write_cond, nw_ir_write, nw_mem_read, nw_mem_write;
  logic       nw_reg_write, nw_alu_src_a, nw_mem_to_reg, nw_pc_source, nw_illegal;
  logic [1:0] nw_alu_src_b, nw_alu_op;
  logic [3:0] nw_retired;

  multicycle_cu #(.CNT_W(4), .FETCH_WAIT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg),
    .pc_source(pc_source), .alu_op(alu_op), .illegal(illegal), .retired(retired)
  );

  multicycle_cu #(.CNT_W(4), .FETCH_WAIT(1'b0)) u_nowait (
    .clk(clk), .rst_n(rst_nw), .opcode(opcode_nw), .zero(1'b0), .mem_ready(1'b0),
    .pc_write(nw_pc_write), .pc_write_cond(nw_pc_write_cond), .ir_write(nw_ir_write),
    .mem_read(nw_mem_read), .mem_write(nw_mem_write), .reg_write(nw_reg_write),
    .alu_src_a(nw_alu_src_a), .alu_src_b(nw_alu_src_b), .mem_to_reg(nw_mem_to_reg),
    .pc_source(nw_pc_source), .alu_op(nw_alu_op), .illegal(nw_illegal), .retired(nw_retired)
  );

  typedef enum int {
    PH_RESET, PH_FETCH, PH_DECODE, PH_MEM_ADDR, PH_MEM_RD, PH_MEM_WB,
    PH_MEM_WR, PH_EXEC_R, PH_R_WB, PH_BRANCH, PH_TRAP
  } ph_e;

  typedef struct {
    logic [13:0] vec;
    logic [3:0]  ret;
    ph_e         ph;
  } exp_t;

  // Vector layout: {mr,mw,irw,rw,pcw,pcc,sa,sb[1:0],m2r,ps,aop[1:0],ill}
  localparam int B_MR = 13, B_MW = 12, B_IRW = 11, B_RW = 10, B_PCW = 9, B_PCC = 8;
  localparam int B_SA = 7, B_SB = 5, B_M2R = 4, B_PS = 3, B_AOP = 1, B_ILL = 0;
  localparam logic [6:0] JUNK = 7'h7F;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          model_ret = 0;
  logic [13:0] act_vec;

  assign act_vec = {mem_read, mem_write, ir_write, reg_write, pc_write, pc_write_cond,
                    alu_src_a, alu_src_b, mem_to_reg, pc_source, alu_op, illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [13:0] expect_outs(ph_e p, bit ready);
    logic [13:0] v;
    v = '0;
    case (p)
      PH_RESET:    begin v[B_MR] = 1'b1; v[B_SB+:2] = 2'd1; end
      PH_FETCH:    begin v[B_MR] = 1'b1; v[B_IRW] = 1'b1; v[B_SB+:2] = 2'd1; v[B_PCW] = ready; end
      PH_DECODE:   begin v[B_SB+:2] = 2'd2; end
      PH_MEM_ADDR: begin v[B_SA] = 1'b1; v[B_SB+:2] = 2'd2; end
      PH_MEM_RD:   begin v[B_MR] = 1'b1; end
      PH_MEM_WB:   begin v[B_RW] = 1'b1; v[B_M2R] = 1'b1; end
      PH_MEM_WR:   begin v[B_MW] = 1'b1; end
      PH_EXEC_R:   begin v[B_SA] = 1'b1; v[B_AOP+:2] = 2'd2; end
      PH_R_WB:     begin v[B_RW] = 1'b1; end
      PH_BRANCH:   begin v[B_SA] = 1'b1; v[B_AOP+:2] = 2'd1; v[B_PCC] = 1'b1; v[B_PS] = 1'b1; end
      default:     begin v[B_ILL] = 1'b1; end
    endcase
    return v;
  endfunction

  always @(negedge clk) begin : cmp_p
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk($sformatf("outs@%s", e.ph.name()), 32'(act_vec), 32'(e.vec));
      chk($sformatf("retired@%s", e.ph.name()), 32'(retired), 32'(e.ret));
    end
  end

  task automatic cyc(input ph_e p, input bit rdy, input logic [6:0] op, input bit zr);
    exp_t e;
    mem_ready = rdy;
    opcode    = op;
    zero      = zr;
    e.vec = expect_outs(p, rdy);
    e.ret = 4'(model_ret);
    e.ph  = p;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One instruction: fwait stalled fetch cycles, mwait stalled memory cycles.
  task automatic run_instr(input logic [6:0] op, input bit zr, input int fwait, input int mwait);
    repeat (fwait) cyc(PH_FETCH, 1'b0, JUNK, 1'b0);
    cyc(PH_FETCH, 1'b1, JUNK, 1'b0);
    cyc(PH_DECODE, 1'b0, op, 1'b0);
    case (op)
      OP_LOAD: begin
        cyc(PH_MEM_ADDR, 1'b1, JUNK, 1'b0);
        repeat (mwait) cyc(PH_MEM_RD, 1'b0, JUNK, 1'b0);
        cyc(PH_MEM_RD, 1'b1, JUNK, 1'b0);
        cyc(PH_MEM_WB, 1'b0, JUNK, 1'b0);
        model_ret++;
      end
      OP_STORE: begin
        cyc(PH_MEM_ADDR, 1'b0, JUNK, 1'b0);
        repeat (mwait) cyc(PH_MEM_WR, 1'b0, JUNK, 1'b0);
        cyc(PH_MEM_WR, 1'b1, JUNK, 1'b0);
        model_ret++;
      end
      OP_RTYPE: begin
        cyc(PH_EXEC_R, 1'b0, JUNK, 1'b0);
        cyc(PH_R_WB, 1'b1, JUNK, 1'b0);
        model_ret++;
      end
      OP_BRANCH: begin
        cyc(PH_BRANCH, 1'b0, JUNK, zr);
        model_ret++;
      end
      default: ;
    endcase
  endtask

  initial begin
    rst_n     = 1'b0;
    rst_nw    = 1'b0;
    mem_ready = 1'b0;
    opcode    = JUNK;
    zero      = 1'b0;
    opcode_nw = OP_LOAD;
    @(posedge clk);
    #1;
    cyc(PH_RESET, 1'b1, OP_RTYPE, 1'b0);
    chk("retired_in_reset", 32'(retired), 32'd0);

    // No-wait build: load takes 5 cycles, store 4, with mem_ready held low.
    rst_nw = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("nowait_load_4cyc", 32'(nw_retired), 32'd0);
    @(posedge clk);
    #1;
    chk("nowait_load_5cyc", 32'(nw_retired), 32'd1);
    opcode_nw = OP_STORE;
    repeat (3) @(posedge clk);
    #1;
    chk("nowait_store_3cyc", 32'(nw_retired), 32'd1);
    @(posedge clk);
    #1;
    chk("nowait_store_4cyc", 32'(nw_retired), 32'd2);

    rst_n = 1'b1;
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    chk("retired_after_rtype", 32'(retired), 32'd1);
    run_instr(OP_LOAD, 1'b0, 1, 3);
    chk("retired_after_load", 32'(retired), 32'd2);
    run_instr(OP_STORE, 1'b0, 0, 2);
    run_instr(OP_BRANCH, 1'b0, 0, 0);
    run_instr(OP_BRANCH, 1'b1, 0, 0);
    chk("retired_after_branches", 32'(retired), 32'd5);

    // Store abandoned by an asynchronous reset between clock edges.
    cyc(PH_FETCH, 1'b1, JUNK, 1'b0);
    cyc(PH_DECODE, 1'b0, OP_STORE, 1'b0);
    cyc(PH_MEM_ADDR, 1'b0, JUNK, 1'b0);
    cyc(PH_MEM_WR, 1'b0, JUNK, 1'b0);
    cyc(PH_MEM_WR, 1'b0, JUNK, 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("mem_write_before_rst", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mem_write_async_drop", 32'(mem_write), 32'd0);
    chk("retired_async_clear", 32'(retired), 32'd0);
    chk("reg_write_after_rst", 32'(reg_write), 32'd0);
    model_ret = 0;
    cyc(PH_RESET, 1'b1, JUNK, 1'b0);
    cyc(PH_RESET, 1'b1, JUNK, 1'b0);
    rst_n = 1'b1;
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    chk("retired_after_rst_rtype", 32'(retired), 32'd1);

    // Illegal opcode parks in TRAP regardless of later inputs.
    run_instr(JUNK, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc(PH_TRAP, i[0], (i[1] ? OP_RTYPE : OP_LOAD), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("illegal_async_clear", 32'(illegal), 32'd0);
    chk("fetch_after_trap_rst", 32'(mem_read), 32'd1);
    model_ret = 0;
    cyc(PH_RESET, 1'b0, JUNK, 1'b0);
    rst_n = 1'b1;

    // CNT_W=4: fifteen instructions reach all-ones, the sixteenth wraps.
    for (int i = 0; i < 15; i++) run_instr(OP_RTYPE, 1'b0, 0, 0);
    chk("retired_all_ones", 32'(retired), 32'd15);
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    chk("retired_wrap", 32'(retired), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Parameter FETCH_WAIT, default 1, when 1 fetch/memory states wait for mem_ready; when 0 memory is single-cycle and mem_ready is ignored.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  7  instruction opcode bits [6:0], sampled from instruction register in DECODE.
REQ-006 zero  input  1  ALU zero flag, used in BRANCH.
REQ-007 mem_ready  input  1  memory handshake, access completes in the cycle mem_ready=1.
REQ-008 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  output  1 each  datapath enables.
REQ-009 alu_src_a  output  1 (0=PC, 1=rs1); alu_src_b  output  2 (0=rs2, 1=const 4, 2=imm); mem_to_reg  output  1; pc_source  output  1 (0=ALU result, 1=ALU out register).
REQ-010 alu_op  output  2  ALU control-unit op: 0=load/store add, 1=BEQ subtract, 2=R-type (funct-decoded).
REQ-011 illegal  output  1  sticky unsupported-opcode flag; retired  output  CNT_W  instructions completed.

Function
REQ-012 Controller SHALL be a Moore FSM; all outputs except counter decode from current state only.
REQ-013 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, TRAP.
REQ-014 FETCH: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=0, pc_write=1 only in the cycle mem_ready=1; stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
REQ-015 DECODE: alu_src_a=0, alu_src_b=2, alu_op=0 (branch target precompute); next state by opcode: 0000011 or 0100011 -> MEM_ADDR, 0110011 -> EXEC_R, 1100011 -> BRANCH, other -> TRAP.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; next MEM_RD if load else MEM_WR.
REQ-017 MEM_RD: mem_read=1; holds until mem_ready=1, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1; next FETCH.
REQ-018 MEM_WR: mem_write=1; holds until mem_ready=1, then FETCH.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2; next R_WB. R_WB: reg_write=1, mem_to_reg=0; next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1; PC updates only when zero=1; next FETCH regardless of zero.
REQ-021 TRAP: all enables 0, illegal=1; FSM stays in TRAP until reset.
REQ-022 Opcode decode in DECODE uses the opcode value of that cycle; opcode changes in other states have no effect.
REQ-023 retired SHALL increment by 1 on exit of MEM_WB, MEM_WR (mem_ready=1), R_WB and BRANCH; wraps from all-ones to 0 without flag.
REQ-024 Cycle counts with mem_ready tied 1: R-type 4, BEQ 3, load 5, store 4.
REQ-025 In any state, unused outputs SHALL be 0; mem_read and mem_write never both 1.
REQ-026 With FETCH_WAIT=0, waiting states advance unconditionally after one cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force state FETCH, retired=0, illegal=0, independent of clk.
REQ-028 Reset asserted mid-instruction (including MEM_RD/MEM_WR wait) SHALL abandon the instruction with no write enable asserted after reset assertion.
REQ-029 First rising edge after rst_n deasserts evaluates FETCH normally.

Structure
REQ-030 Shared package cu_pkg holds: state enum, opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH), alu_op encodings, alu_src_b encodings.
REQ-031 One sub-module opcode_decoder (combinational, opcode -> instruction class + valid) is instantiated; output decode stays in multicycle_cu.
REQ-032 alu_op drives the existing ALU control unit unchanged; no funct decoding inside this block.

Verification
REQ-033 Reset, mem_ready=1, opcode=0110011 -> states FETCH,DECODE,EXEC_R,R_WB; alu_op=2 in EXEC_R; reg_write pulse 1 cycle; retired=1.
REQ-034 opcode=0000011, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read=1 throughout, then MEM_WB reg_write=1 mem_to_reg=1; retired+1.
REQ-035 opcode=1100011 with zero=0 then zero=1 -> pc_write_cond=1, alu_op=1 both times; retired advances by 2.
REQ-036 opcode=1111111 -> TRAP after DECODE, illegal=1 held 20 cycles, no enables; rst_n pulse clears illegal, state FETCH.
REQ-037 rst_n asserted asynchronously mid-MEM_WR between edges -> mem_write drops same cycle, retired=0, no store completion.
REQ-038 retired preset near max via 2^CNT_W-1 instructions (CNT_W=4 build, 15 R-types + 1) -> retired wraps to 0.
